// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB pixel engine.
// Op codes, FSM encoding, gray weights and saturating arithmetic.
package rgb_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_INV  = 3'd3,
    OP_THR  = 3'd4,
    OP_GRAY = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CALC,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Luma approximation as shift pairs: R*0.28, G*0.56, B*0.09
  localparam int GR_A = 2;
  localparam int GR_B = 5;
  localparam int GG_A = 1;
  localparam int GG_B = 4;
  localparam int GB_A = 4;
  localparam int GB_B = 5;

  function automatic logic [31:0] sat_u(
    input logic [33:0] x,
    input int unsigned dw
  );
    logic [33:0] maxv;
    maxv = (34'd1 << dw) - 34'd1;
    return (x > maxv) ? maxv[31:0] : x[31:0];
  endfunction

  function automatic logic [31:0] sub_floor(
    input logic [31:0] x,
    input logic [31:0] v
  );
    return (x >= v) ? x - v : 32'd0;
  endfunction

endpackage

// File: rtl/rgb_pixel_engine_if.sv
// Sample stream in, result stream out.
// slave = engine side, master = source/sink side.
interface rgb_pixel_engine_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          pause;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  pause, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output pause, out_valid, out_data
  );
endinterface

// File: rtl/pix_fifo.sv
// Result FIFO: up to WN entries written per cycle, one read.
// Synchronous flush drops all contents.
module pix_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 6,
  parameter int WN    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic                         wr_one,
  input  logic [WN-1:0][DW-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DW-1:0]                rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  int            n_wr;
  int            n_rd;

  function automatic logic [AW-1:0] wrap(input int p);
    return (p >= DEPTH) ? AW'(p - DEPTH) : AW'(p);
  endfunction

  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];
  assign n_wr    = !wr_en ? 0 : (wr_one ? 1 : WN);
  assign n_rd    = (rd_en && !empty) ? 1 : 0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < WN; i++)
        if (i < n_wr) mem[wrap(int'(wr_ptr) + i)] <= wr_data[i];
      wr_ptr <= wrap(int'(wr_ptr) + n_wr);
      rd_ptr <= wrap(int'(rd_ptr) + n_rd);
      count  <= CW'(int'(count) + n_wr - n_rd);
    end
  end

endmodule

// File: rtl/rgb_pixel_engine.sv
// Per-pixel colour operator: gathers NCH samples, applies the
// latched op, queues results and pulses done at end of frame.
module rgb_pixel_engine
  import rgb_pkg::*;
#(
  parameter int DW         = 8,
  parameter int NCH        = 3,
  parameter int IMG_W      = 450,
  parameter int IMG_H      = 450,
  parameter int FIFO_DEPTH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [2:0]          op_sel,
  input  logic [DW-1:0]       op_value,
  rgb_pixel_engine_if.slave   px,
  output logic                busy,
  output logic                done
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [DW-1:0] MAXV = '1;

  state_e                  state;
  logic                    en_q;
  logic [2:0]              op_q;
  logic [DW-1:0]           val_q;
  logic [CHW-1:0]          ch_cnt;
  logic [PW-1:0]           pix_cnt;
  logic [DW-1:0]           ch_reg [NCH];
  logic [NCH-1:0][DW-1:0]  res;
  logic [DW+1:0]           gray_sum;
  logic [DW-1:0]           gray_res;
  logic [DW-1:0]           fifo_rd;
  logic [FCW-1:0]          fifo_cnt;
  logic                    fifo_empty;
  logic                    gray_mode;
  logic                    take;
  logic                    abort;
  logic                    push;
  int                      rpp;

  function automatic logic [DW+1:0] ext(input logic [DW-1:0] x);
    return {2'b00, x};
  endfunction

  assign gray_mode = (NCH == 3) && (op_q == OP_GRAY);
  assign rpp       = gray_mode ? 1 : NCH;
  assign abort     = !en && (state inside {ST_FILL, ST_CALC, ST_DRAIN});
  assign push      = (state == ST_CALC) && en;
  assign take      = (state == ST_FILL) && px.in_valid && !px.pause;

  // Free space is checked before the pixel completes, so CALC never overflows
  assign px.pause     = (state != ST_FILL) ||
                        (int'(fifo_cnt) + rpp > FIFO_DEPTH);
  assign px.out_valid = !fifo_empty;
  assign px.out_data  = fifo_empty ? '0 : fifo_rd;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

  generate
    if (NCH == 3) begin : g_gray
      assign gray_sum = ext(ch_reg[0] >> GR_A) + ext(ch_reg[0] >> GR_B)
                      + ext(ch_reg[1] >> GG_A) + ext(ch_reg[1] >> GG_B)
                      + ext(ch_reg[2] >> GB_A) + ext(ch_reg[2] >> GB_B);
    end else begin : g_nogray
      assign gray_sum = '0;
    end
  endgenerate

  assign gray_res = DW'(sat_u(34'(gray_sum), DW));

  always_comb begin
    res = '0;
    for (int i = 0; i < NCH; i++) begin
      res[i] = ch_reg[i];
      unique case (1'b1)
        op_q == OP_ADD:
          res[i] = DW'(sat_u(34'(ch_reg[i]) + 34'(val_q), DW));
        op_q == OP_SUB:
          res[i] = DW'(sub_floor(32'(ch_reg[i]), 32'(val_q)));
        op_q == OP_INV:
          res[i] = MAXV - ch_reg[i];
        op_q == OP_THR:
          res[i] = (ch_reg[i] >= val_q) ? MAXV : '0;
        gray_mode:
          res[i] = (i == 0) ? gray_res : ch_reg[i];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      en_q    <= 1'b0;
      op_q    <= '0;
      val_q   <= '0;
      ch_cnt  <= '0;
      pix_cnt <= '0;
      for (int i = 0; i < NCH; i++) ch_reg[i] <= '0;
    end else begin
      en_q <= en;
      if (abort) begin
        state   <= ST_IDLE;
        ch_cnt  <= '0;
        pix_cnt <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (en && !en_q) begin
              state   <= ST_FILL;
              op_q    <= op_sel;
              val_q   <= op_value;
              ch_cnt  <= '0;
              pix_cnt <= '0;
            end
          end
          ST_FILL: begin
            if (take) begin
              ch_reg[ch_cnt] <= px.in_data;
              if (ch_cnt == CHW'(NCH - 1)) begin
                ch_cnt <= '0;
                state  <= ST_CALC;
              end else begin
                ch_cnt <= ch_cnt + 1'b1;
              end
            end
          end
          ST_CALC: begin
            pix_cnt <= pix_cnt + 1'b1;
            state   <= (pix_cnt == PW'(NPIX - 1)) ? ST_DRAIN : ST_FILL;
          end
          ST_DRAIN: begin
            if (fifo_empty) state <= ST_DONE;
          end
          ST_DONE: begin
            state   <= ST_IDLE;
            pix_cnt <= '0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  pix_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH),
    .WN    (NCH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .wr_en   (push),
    .wr_one  (gray_mode),
    .wr_data (res),
    .rd_en   (px.out_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

endmodule
